// File: rtl/msrh_disp_fifo.sv
// Group-granular dispatch FIFO between rename and the schedulers/ROB allocation.
// MSRH_DISP_FIFO_BYPASS_EN enables an empty-FIFO same-cycle passthrough of the input group.
module msrh_disp_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DISP_SIZE = 2,
    parameter int unsigned VADDR_W   = 39,
    parameter int unsigned CMT_BLK_W = 4,
    parameter int unsigned DISP_W    = 64
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,

    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [VADDR_W-1:0]                   i_pc_addr,
    input  logic                                 i_is_br_included,
    input  logic [CMT_BLK_W-1:0]                 i_cmt_id,
    input  logic [DISP_SIZE-1:0][DISP_W-1:0]     i_inst,

    input  logic                                 i_flush,

    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [VADDR_W-1:0]                   o_pc_addr,
    output logic                                 o_is_br_included,
    output logic [CMT_BLK_W-1:0]                 o_cmt_id,
    output logic [DISP_SIZE-1:0][DISP_W-1:0]     o_inst,

    output logic [$clog2(DEPTH):0]               o_count,
    output logic                                 o_full,
    output logic                                 o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

    typedef struct packed {
        logic [VADDR_W-1:0]               pc_addr;
        logic                             is_br_included;
        logic [CMT_BLK_W-1:0]             cmt_id;
        logic [DISP_SIZE-1:0][DISP_W-1:0] inst;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            in_entry;
    entry_t            head_entry;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  count;
    logic              full, empty;
    logic              push, pop, bypass;

    assign in_entry = '{pc_addr:        i_pc_addr,
                        is_br_included: i_is_br_included,
                        cmt_id:         i_cmt_id,
                        inst:           i_inst};

    // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy directly.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

`ifdef MSRH_DISP_FIFO_BYPASS_EN
    assign bypass     = empty & i_valid & i_ready & ~i_flush;
    assign head_entry = bypass ? in_entry : mem_q[rd_ptr_q[IDX_W-1:0]];
`else
    assign bypass     = 1'b0;
    assign head_entry = mem_q[rd_ptr_q[IDX_W-1:0]];
`endif

    // Ready comes from registered state only; a pop cannot free a slot for the same cycle.
    assign push = i_valid & ~full & ~i_flush & ~bypass;
    assign pop  = ~empty & ~i_flush & i_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= in_entry;
    end

    assign o_ready          = ~full;
    assign o_valid          = (~empty & ~i_flush) | bypass;
    assign o_pc_addr        = head_entry.pc_addr;
    assign o_is_br_included = head_entry.is_br_included;
    assign o_cmt_id         = head_entry.cmt_id;
    assign o_inst           = head_entry.inst;
    assign o_count          = count;
    assign o_full           = full;
    assign o_empty          = empty;

endmodule

// File: tb/tb_msrh_disp_fifo.sv
// Directed, table-driven bench for msrh_disp_fifo; expectations follow the
// MSRH_DISP_FIFO_BYPASS_EN setting of the build.
module tb_msrh_disp_fifo;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned DISP_SIZE = 2;
    localparam int unsigned VADDR_W   = 16;
    localparam int unsigned CMT_BLK_W = 5;
    localparam int unsigned DISP_W    = 8;
`ifdef MSRH_DISP_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                             i_clk = 1'b0;
    logic                             i_reset_n;
    logic                             i_valid, i_ready, i_flush;
    logic                             o_ready, o_valid;
    logic [VADDR_W-1:0]               i_pc_addr, o_pc_addr;
    logic                             i_is_br_included, o_is_br_included;
    logic [CMT_BLK_W-1:0]             i_cmt_id, o_cmt_id;
    logic [DISP_SIZE-1:0][DISP_W-1:0] i_inst, o_inst;
    logic [$clog2(DEPTH):0]           o_count;
    logic                             o_full, o_empty;

    msrh_disp_fifo #(
        .DEPTH(DEPTH), .DISP_SIZE(DISP_SIZE), .VADDR_W(VADDR_W),
        .CMT_BLK_W(CMT_BLK_W), .DISP_W(DISP_W)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc_addr(i_pc_addr), .i_is_br_included(i_is_br_included),
        .i_cmt_id(i_cmt_id), .i_inst(i_inst),
        .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_pc_addr(o_pc_addr), .o_is_br_included(o_is_br_included),
        .o_cmt_id(o_cmt_id), .o_inst(o_inst),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit v, r, f;
        int cmt;
        bit ov;
        int oc;
        int cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(bit v, bit r, bit f, int cmt, bit ov, int oc, int cnt);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.cmt = cmt; t.ov = ov; t.oc = oc; t.cnt = cnt;
        return t;
    endfunction

    function automatic logic [VADDR_W-1:0] pc_of(input logic [4:0] c);
        return 16'h1000 + {9'd0, c, 2'b00};
    endfunction

    function automatic logic [DISP_SIZE-1:0][DISP_W-1:0] inst_of(input logic [4:0] c);
        return {({3'd0, c} + 8'h40), ({3'd0, c} ^ 8'hA5)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input int c);
        logic [4:0] c5;
        c5 = 5'(c);
        i_valid = v; i_ready = r; i_flush = f;
        i_cmt_id = c5; i_pc_addr = pc_of(c5);
        i_is_br_included = c5[0]; i_inst = inst_of(c5);
    endtask

    // One cycle: drive just after the edge, sample mid-cycle, then advance.
    task automatic step(input string nm, input bit v, input bit r, input bit f, input int c,
                        input bit ov, input int oc, input int cnt);
        logic [4:0] oc5;
        oc5 = 5'(oc);
        drive(v, r, f, c);
        #4;
        chk({nm, ".valid"}, 32'(o_valid), 32'(ov));
        chk({nm, ".count"}, 32'(o_count), 32'(cnt));
        chk({nm, ".full"},  32'(o_full),  32'(cnt == DEPTH));
        chk({nm, ".empty"}, 32'(o_empty), 32'(cnt == 0));
        chk({nm, ".ready"}, 32'(o_ready), 32'(cnt != DEPTH));
        if (ov) begin
            chk({nm, ".cmt_id"}, 32'(o_cmt_id), 32'(oc5));
            chk({nm, ".pc"},     32'(o_pc_addr), 32'(pc_of(oc5)));
            chk({nm, ".br"},     32'(o_is_br_included), 32'(oc5[0]));
            chk({nm, ".inst"},   32'(o_inst), 32'(inst_of(oc5)));
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.count", 32'(o_count), 32'd0);
        chk("rst.empty", 32'(o_empty), 32'd1);
        chk("rst.full",  32'(o_full),  32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        //            v  r  f cmt  ov oc cnt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));   // idle
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));   // fill 1..4, no pop
        tbl.push_back(mk(1, 0, 0, 2, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 3, 1, 1, 2));
        tbl.push_back(mk(1, 0, 0, 4, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4));   // full
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 4));   // drain in order
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 3));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));   // refill
        tbl.push_back(mk(1, 0, 0, 2, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 3, 1, 1, 2));
        tbl.push_back(mk(1, 0, 0, 4, 1, 1, 3));
        tbl.push_back(mk(1, 1, 0, 5, 1, 1, 4));   // full: pop ok, push 5 refused
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 3));
        tbl.push_back(mk(1, 1, 1, 6, 0, 0, 3));   // flush beats push and pop
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 9, 0, 0, 0));   // first group after flush
        tbl.push_back(mk(0, 1, 0, 0, 1, 9, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));   // flush while empty
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].cmt,
                 tbl[i].ov, tbl[i].oc, tbl[i].cnt);

        // Streaming push+pop every cycle across pointer wrap.
        for (int i = 0; i < 20; i++)
            step($sformatf("stream%0d", i), 1, 1, 0, i,
                 BYP ? 1'b1 : (i > 0), BYP ? i : i - 1, BYP ? 0 : (i > 0 ? 1 : 0));
        step("stream_drain", 0, 1, 0, 0, !BYP, 19, BYP ? 0 : 1);
        step("stream_idle", 0, 0, 0, 0, 0, 0, 0);

        // Empty FIFO with push and pop in the same cycle.
        step("byp_push", 1, 1, 0, 7, BYP, 7, 0);
        step("byp_next", 0, 1, 0, 0, !BYP, 7, BYP ? 0 : 1);
        step("byp_idle", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in mid-cycle discards contents without a clock edge.
        step("ar_push0", 1, 0, 0, 10, 0, 0, 0);
        step("ar_push1", 1, 0, 0, 11, 1, 10, 1);
        drive(0, 0, 0, 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst.valid", 32'(o_valid), 32'd0);
        chk("arst.count", 32'(o_count), 32'd0);
        chk("arst.empty", 32'(o_empty), 32'd1);
        chk("arst.ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        step("arst_idle", 0, 0, 0, 0, 0, 0, 0);
        step("arst_push", 1, 0, 0, 12, 0, 0, 0);
        step("arst_pop", 0, 1, 0, 0, 1, 12, 1);
        step("arst_end", 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
